// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match, write/read byte service.
// Optional I2C_GENERAL_CALL_EN additionally accepts the general-call address (7'h00, write only).
module i2c_slave_responder #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'h42
) (
   input  logic       clock,
   input  logic       Reset,
   input  logic       SCLIn,
   input  logic       SDAIn,
   output logic       SDADriveLow,
   input  logic [7:0] TransmitData,
   output logic       TransmitRequest,
   output logic [7:0] ReceivedData,
   output logic       DataValid,
   output logic       Busy,
   output logic       ReadMode
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WRITE_DATA,
      WRITE_ACK,
      READ_DATA,
      READ_ACK,
      WAIT_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  scl_sync_q, scl_sync_d;
   logic [2:0]  sda_sync_q, sda_sync_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shift_q, shift_d;
   logic        sda_low_q, sda_low_d;
   logic        treq_q, treq_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        dv_q, dv_d;
   logic        busy_q, busy_d;
   logic        read_mode_q, read_mode_d;

   logic        scl_s, sda_s;
   logic        scl_rise, scl_fall, sda_rise, sda_fall;
   logic        start_det, stop_det;
   logic [7:0]  byte_in;
   logic        addr_match;

   // [1] is the synchronized level, [2] its one-clock-old copy for edge strobes
   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
   assign sda_rise  = sda_sync_q[1] & ~sda_sync_q[2];
   assign sda_fall  = ~sda_sync_q[1] & sda_sync_q[2];
   assign start_det = scl_s & sda_fall;
   assign stop_det  = scl_s & sda_rise;
   assign byte_in   = {shift_q, sda_s};

`ifdef I2C_GENERAL_CALL_EN
   assign addr_match = (byte_in[7:1] == SLAVE_ADDRESS) || (byte_in == 8'h00);
`else
   assign addr_match = (byte_in[7:1] == SLAVE_ADDRESS);
`endif

   always_comb begin
      state_d     = state_q;
      scl_sync_d  = {scl_sync_q[1:0], SCLIn};
      sda_sync_d  = {sda_sync_q[1:0], SDAIn};
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      sda_low_d   = sda_low_q;
      treq_d      = 1'b0;
      rx_data_d   = rx_data_q;
      dv_d        = 1'b0;
      busy_d      = busy_q;
      read_mode_d = read_mode_q;

      if (stop_det) begin
         state_d   = IDLE;
         busy_d    = 1'b0;
         sda_low_d = 1'b0;
         bit_cnt_d = '0;
      end else if (start_det) begin
         state_d   = ADDR;
         sda_low_d = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = byte_in[6:0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (addr_match) begin
                        read_mode_d = byte_in[0];
                        busy_d      = 1'b1;
                        state_d     = ADDR_ACK;
                     end else begin
                        state_d   = WAIT_STOP;
                        bit_cnt_d = '0;
                     end
                  end
               end
            end
            // bit_cnt 8 = before the ACK clock, 0 = ACK clock has risen
            ADDR_ACK: begin
               if (scl_rise) begin
                  bit_cnt_d = '0;
                  treq_d    = read_mode_q;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_low_d = 1'b1;
                  end else if (read_mode_q) begin
                     shift_d   = TransmitData[6:0];
                     sda_low_d = ~TransmitData[7];
                     state_d   = READ_DATA;
                  end else begin
                     sda_low_d = 1'b0;
                     state_d   = WRITE_DATA;
                  end
               end
            end
            WRITE_DATA: begin
               if (scl_rise) begin
                  shift_d   = byte_in[6:0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     rx_data_d = byte_in;
                     dv_d      = 1'b1;
                     state_d   = WRITE_ACK;
                  end
               end
            end
            WRITE_ACK: begin
               if (scl_rise) begin
                  bit_cnt_d = '0;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_low_d = 1'b1;
                  end else begin
                     sda_low_d = 1'b0;
                     state_d   = WRITE_DATA;
                  end
               end
            end
            READ_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_low_d = 1'b0;
                     state_d   = READ_ACK;
                  end else begin
                     sda_low_d = ~shift_q[6];
                     shift_d   = {shift_q[5:0], 1'b0};
                  end
               end
            end
            READ_ACK: begin
               if (scl_rise) begin
                  bit_cnt_d = '0;
                  if (!sda_s) begin
                     treq_d = 1'b1;
                  end else begin
                     sda_low_d = 1'b0;
                     state_d   = WAIT_STOP;
                  end
               end else if (scl_fall && (bit_cnt_q == 4'd0)) begin
                  shift_d   = TransmitData[6:0];
                  sda_low_d = ~TransmitData[7];
                  state_d   = READ_DATA;
               end
            end
            WAIT_STOP: sda_low_d = 1'b0;
            default: begin
               state_d   = IDLE;
               sda_low_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         scl_sync_q  <= '1;
         sda_sync_q  <= '1;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         sda_low_q   <= 1'b0;
         treq_q      <= 1'b0;
         rx_data_q   <= '0;
         dv_q        <= 1'b0;
         busy_q      <= 1'b0;
         read_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         scl_sync_q  <= scl_sync_d;
         sda_sync_q  <= sda_sync_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         sda_low_q   <= sda_low_d;
         treq_q      <= treq_d;
         rx_data_q   <= rx_data_d;
         dv_q        <= dv_d;
         busy_q      <= busy_d;
         read_mode_q <= read_mode_d;
      end
   end

   assign SDADriveLow     = sda_low_q;
   assign TransmitRequest = treq_q;
   assign ReceivedData    = rx_data_q;
   assign DataValid       = dv_q;
   assign Busy            = busy_q;
   assign ReadMode        = read_mode_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bench acts as I2C controller on an open-drain bus model.
// Received bytes and read-data requests are checked by scoreboard monitors.
module tb_i2c_slave_responder;

   localparam int unsigned Q = 5;   // system clocks per quarter SCL period

   logic       clock;
   logic       Reset;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       SDADriveLow;
   logic [7:0] TransmitData;
   logic       TransmitRequest;
   logic [7:0] ReceivedData;
   logic       DataValid;
   logic       Busy;
   logic       ReadMode;

   int n_tests = 0;
   int n_fail  = 0;
   int dv_cnt  = 0;
   int treq_cnt = 0;
   logic drv_seen;
   logic dv_prev;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_tx[$];

   assign sda_bus = sda_m & ~SDADriveLow;

   i2c_slave_responder #(.SLAVE_ADDRESS(7'h42)) dut (
      .clock          (clock),
      .Reset          (Reset),
      .SCLIn          (scl_m),
      .SDAIn          (sda_bus),
      .SDADriveLow    (SDADriveLow),
      .TransmitData   (TransmitData),
      .TransmitRequest(TransmitRequest),
      .ReceivedData   (ReceivedData),
      .DataValid      (DataValid),
      .Busy           (Busy),
      .ReadMode       (ReadMode)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge clock);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; qwait();
      sda_m = 1'b0; qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; qwait();
      scl_m = 1'b1; qwait();
      sda_m = 1'b1; qwait();
      qwait();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    qwait();
      scl_m = 1'b1; qwait(); qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; qwait();
      b = sda_bus;  qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack_bit);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(ack_bit);
   endtask

   // DataValid scoreboard: each new pulse pops one expected byte; pulse must last one clock
   initial begin
      dv_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (dv_prev) begin
            check("dv_width", DataValid, 0);
         end else if (DataValid) begin
            dv_cnt++;
            if (exp_rx.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL dv_unexpected: got %0h expected no DataValid", ReceivedData);
            end else begin
               check("rx_data", ReceivedData, exp_rx.pop_front());
            end
         end
         dv_prev = DataValid;
      end
   end

   // TransmitRequest scoreboard: each pulse pops the byte the user side supplies
   initial begin
      forever begin
         @(negedge clock);
         if (Reset && TransmitRequest) begin
            treq_cnt++;
            if (exp_tx.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL treq_unexpected: got TransmitRequest expected none");
            end else begin
               TransmitData = exp_tx.pop_front();
               check("treq_readmode", ReadMode, 1);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         if (SDADriveLow) drv_seen = 1'b1;
      end
   end

   initial begin
      logic       ack;
      logic [7:0] d;
      int         dv_before;
      int         dv_exp;

      Reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; TransmitData = 8'h00; drv_seen = 1'b0;
      repeat (5) @(negedge clock);
      check("rst_sda",  SDADriveLow, 0);
      check("rst_treq", TransmitRequest, 0);
      check("rst_rx",   ReceivedData, 8'h00);
      check("rst_dv",   DataValid, 0);
      check("rst_busy", Busy, 0);
      check("rst_rm",   ReadMode, 0);
      Reset = 1'b1;
      repeat (5) @(negedge clock);

      // write transfer
      i2c_start();
      write_byte(8'h84, ack);
      check("wr_addr_ack", ack, 0);
      check("wr_busy", Busy, 1);
      check("wr_readmode", ReadMode, 0);
      exp_rx.push_back(8'hA5);
      write_byte(8'hA5, ack);
      check("wr_data_ack", ack, 0);
      i2c_stop();
      check("wr_busy_stop", Busy, 0);
      check("wr_dv_count", dv_cnt, 1);

      // address mismatch
      drv_seen = 1'b0;
      i2c_start();
      write_byte(8'h86, ack);
      check("mm_nack", ack, 1);
      check("mm_no_drive", drv_seen, 0);
      check("mm_busy", Busy, 0);
      i2c_stop();

      // read transfer with ACK then NACK
      exp_tx.push_back(8'h3C);
      exp_tx.push_back(8'hC3);
      i2c_start();
      write_byte(8'h85, ack);
      check("rd_addr_ack", ack, 0);
      check("rd_readmode", ReadMode, 1);
      read_byte(d, 1'b0);
      check("rd_byte0", d, 8'h3C);
      read_byte(d, 1'b1);
      check("rd_byte1", d, 8'hC3);
      check("rd_released", SDADriveLow, 0);
      i2c_stop();
      check("rd_treq_count", treq_cnt, 2);
      check("rd_busy_stop", Busy, 0);

      // repeated start after three data bits of a write
      dv_before = dv_cnt;
      exp_tx.push_back(8'hFF);
      i2c_start();
      write_byte(8'h84, ack);
      check("rs_addr0_ack", ack, 0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      i2c_start();
      write_byte(8'h85, ack);
      check("rs_addr1_ack", ack, 0);
      check("rs_readmode", ReadMode, 1);
      read_byte(d, 1'b1);
      check("rs_byte", d, 8'hFF);
      i2c_stop();
      check("rs_no_dv", dv_cnt, dv_before);

      // asynchronous reset while the slave drives a 0 data bit
      exp_tx.push_back(8'h00);
      i2c_start();
      write_byte(8'h85, ack);
      check("ar_addr_ack", ack, 0);
      check("ar_driving", SDADriveLow, 1);
      Reset = 1'b0;
      #1;
      check("ar_sda", SDADriveLow, 0);
      check("ar_busy", Busy, 0);
      check("ar_rm", ReadMode, 0);
      check("ar_rx", ReceivedData, 8'h00);
      repeat (3) @(negedge clock);
      Reset = 1'b1;
      repeat (3) @(negedge clock);
      exp_rx.push_back(8'h11);
      i2c_start();
      write_byte(8'h84, ack);
      check("ar_post_ack", ack, 0);
      write_byte(8'h11, ack);
      check("ar_post_data_ack", ack, 0);
      i2c_stop();
      check("ar_post_busy", Busy, 0);

      // general call
`ifdef I2C_GENERAL_CALL_EN
      exp_rx.push_back(8'h5A);
      i2c_start();
      write_byte(8'h00, ack);
      check("gc_addr_ack", ack, 0);
      check("gc_readmode", ReadMode, 0);
      write_byte(8'h5A, ack);
      check("gc_data_ack", ack, 0);
      i2c_stop();
      dv_exp = 3;
`else
      drv_seen = 1'b0;
      i2c_start();
      write_byte(8'h00, ack);
      check("gc_nack", ack, 1);
      check("gc_no_drive", drv_seen, 0);
      i2c_stop();
      dv_exp = 2;
`endif

      repeat (5) @(negedge clock);
      check("end_rx_queue", exp_rx.size(), 0);
      check("end_tx_queue", exp_tx.size(), 0);
      check("end_treq_count", treq_cnt, 4);
      check("end_dv_count", dv_cnt, dv_exp);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (slave) side of the lab7 bus: the responder to the I2C controller that is clocked by the baud-rate generator.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, receives write bytes and serves read bytes.
- Sits between the open-drain pad logic and user register/file logic.

Parameters:
SLAVE_ADDRESS, 7'h42, 7-bit address this block answers to.

Ports:
clock  input  1  system clock; must be at least 8x the SCL rate.
Reset  input  1  asynchronous, active-low reset (0 = reset).
SCLIn  input  1  raw SCL pin level.
SDAIn  input  1  raw SDA pin level.
SDADriveLow  output  1  1 = pull SDA low (open-drain enable); 0 = release.
TransmitData  input  8  byte to send during a read transfer.
TransmitRequest  output  1  one-clock pulse: supply the next read byte.
ReceivedData  output  8  last byte written by the master.
DataValid  output  1  one-clock pulse: ReceivedData updated.
Busy  output  1  1 from START to STOP while addressed.
ReadMode  output  1  R/W bit of the current matched address byte.

Behaviour:
- Reset (Reset=0, async): state IDLE; SDADriveLow=0, TransmitRequest=0, ReceivedData=8'h00, DataValid=0, Busy=0, ReadMode=0; shift register and bit counter cleared. Takes effect mid-byte with SDA released immediately.
- Sync: SCLIn and SDAIn each pass through a 2-flop synchronizer. Edges are detected on the synced values. "Rise"/"fall" below means the single-clock edge strobe.
- START: synced SDA falls while synced SCL=1. STOP: synced SDA rises while synced SCL=1.
  - START from any state goes to ADDR (repeated start supported) and clears the bit counter.
  - STOP from any state goes to IDLE, sets Busy=0 and releases SDA.
- Data sampling: MSB first, sampled on SCL rise. SDADriveLow changes only on SCL fall.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - On the 8th rise, compare bits[7:1] to SLAVE_ADDRESS.
    - Match: latch ReadMode=bit0, set Busy=1, go to ADDR_ACK.
    - No match: go to WAIT_STOP.
  - ADDR_ACK:
    - Next fall: SDADriveLow=1.
    - 9th rise: if ReadMode, pulse TransmitRequest.
    - Following fall: if write, release SDA and go to WRITE_DATA; if read, load TransmitData into the shift register, drive MSB (SDADriveLow = ~bit7) and go to READ_DATA.
  - WRITE_DATA:
    - Shift 8 bits.
    - One clock after the 8th rise: ReceivedData=byte and DataValid pulses for exactly one clock.
    - Go to WRITE_ACK.
  - WRITE_ACK: next fall SDADriveLow=1; on the following fall release SDA and return to WRITE_DATA.
  - READ_DATA:
    - On each fall, present the next bit.
    - After the 8th bit's fall-out, release SDA on the next fall, then go to READ_ACK.
  - READ_ACK: sample master ACK on the 9th rise.
    - SDA=0 (ACK): pulse TransmitRequest; on the next fall load TransmitData and drive the MSB; go to READ_DATA.
    - SDA=1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released; ignore bus until STOP (to IDLE) or START (to ADDR).
- Bit counter is 4 bits and wraps 0..8 per byte.
- SDADriveLow must never assert in IDLE or WAIT_STOP.
- Simultaneous START/STOP detection with a data edge: START/STOP wins and the data edge is ignored.
- TransmitData is captured only at the load fall, giving the user at least half an SCL period after TransmitRequest.

Optional Feature:
I2C_GENERAL_CALL_EN:
- Defined: address byte 7'h00 with R/W=0 is also matched and ACKed as a write (ReadMode=0). General call with R/W=1 is not matched.
- Undefined: only SLAVE_ADDRESS matches.

Test Plan:
- Write: START, 8'h84, 8'hA5, STOP -> SDA held low on both ACK slots; ReceivedData=8'hA5; exactly one DataValid pulse; Busy returns to 0 after STOP.
- Mismatch: START, 8'h86 -> SDADriveLow stays 0 through the 9th clock; no DataValid or TransmitRequest; Busy=0.
- Read: START, 8'h85; TransmitData=8'h3C then 8'hC3 -> SDA bits 0,0,1,1,1,1,0,0; master ACK; bits 1,1,0,0,0,0,1,1; master NACK -> SDA released, two TransmitRequest pulses total.
- Repeated start: write 8'h84 then START mid-data-byte after 3 bits, then 8'h85 -> no DataValid, ReadMode=1, ACK driven.
- Reset=0 asserted while the slave drives a 0 data bit -> SDADriveLow=0 within the same clock, all outputs at reset values, next START is handled normally.
- With I2C_GENERAL_CALL_EN: START, 8'h00, 8'h5A -> both ACKed, ReceivedData=8'h5A. Without the macro: no ACK.
